control_pipeline: RTL
=====================

Name: control_pipeline

Overview:
Parametrised successor to the combinational DECODE-stage control unit. Decodes the ID-stage opcode into WB/M/EX control bundles, then carries them through the ID/EX, EX/MEM and MEM/WB control registers. Adds load-use hazard detection, bubble insertion, branch flush, a global freeze, an illegal-opcode flag and a saturating bubble counter. Sits between the DECODE stage and the EXECUTE/MEMORY/WRITEBACK stages; the datapath pipeline registers keep their own data fields.

Parameters:
OPCODE_W, 6, opcode width
REG_W, 5, register specifier width
WB_W, 2, WB bundle width: [1] RegWrite, [0] MemtoReg
M_W, 3, M bundle width: [2] Branch, [1] MemRead, [0] MemWrite
EX_W, 4, EX bundle width: [3] RegDst, [2:1] ALUOp, [0] ALUSrc
CNT_W, 16, bubble counter width
HAZARD_EN, 1, 1 enables load-use detection; 0 ties hazard_stall to 0

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
opcode_id  input  OPCODE_W  ID-stage opcode
valid_id  input  1  ID holds a real instruction
rs_id  input  REG_W  ID rs field
rt_id  input  REG_W  ID rt field
stall  input  1  global freeze; all stages hold
flush  input  1  branch taken; squash the ID instruction
ex_ctrl  output  EX_W  EX bundle of the ID/EX stage
m_ctrl  output  M_W  M bundle of the EX/MEM stage
wb_ctrl  output  WB_W  WB bundle of the MEM/WB stage
hazard_stall  output  1  combinational; PC and IF/ID must hold
illegal_op  output  1  registered; ID/EX stage holds an undecoded opcode
bubble_cnt  output  CNT_W  saturating count of bubbles inserted

Behaviour:
- Decode (combinational), all don't-cares resolved to 0:
  - R 000000: WB 10, M 000, EX 1100
  - LW 100011: WB 11, M 010, EX 0001
  - SW 101011: WB 00, M 001, EX 0001
  - BEQ 000100: WB 00, M 100, EX 0010
  - ADDI 001000: WB 10, M 000, EX 0001
  - NOP 100000: all 0
  - Any other opcode: all 0, illegal = 1
  - valid_id=0: all 0, illegal = 0
- Stage registers:
  - S1 (ID/EX): {WB, M, EX, rt, illegal}
  - S2 (EX/MEM): {WB, M}
  - S3 (MEM/WB): {WB}
- Outputs: ex_ctrl = S1.EX; m_ctrl = S2.M; wb_ctrl = S3.WB; illegal_op = S1.illegal.
- Latency: opcode presented in cycle n appears on ex_ctrl at n+1, m_ctrl at n+2 and wb_ctrl at n+3, absent stall.
- hazard_stall = HAZARD_EN & valid_id & S1.M[1] & (S1.rt != 0) & (S1.rt == rs_id | S1.rt == rt_id).
- Per-edge priority:
  1. stall=1: S1, S2, S3 and bubble_cnt all hold. hazard_stall is still driven.
  2. flush=1: S1 <= bubble (all 0, rt=0, illegal=0); S2 <= S1; S3 <= S2; bubble_cnt += 1.
  3. hazard_stall=1: same as flush.
  4. Otherwise: S1 <= decode; S2 <= S1; S3 <= S2.
- flush and hazard in the same cycle insert one bubble and count once.
- bubble_cnt saturates at all-ones; it never wraps.
- Reset: all stage registers, outputs and bubble_cnt go to 0 immediately on rst_n low, including mid-operation. First decode is captured at the first clk edge after rst_n deasserts.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_NOP)
  - bit-index constants for the WB/M/EX fields
  - the bubble constant
- One sub-module, ctrl_decode: purely combinational opcode -> {WB, M, EX, illegal}. Reusable by the existing DECODE stage.

Test Plan:
- Reset: hold rst_n=0 with opcode_id=100011, valid_id=1 -> all outputs 0. Release rst_n; after 1 edge ex_ctrl=0001.
- Sequence R, LW, SW, BEQ, ADDI, NOP on consecutive cycles, no stall -> ex_ctrl 1100, 0001, 0001, 0010, 0001, 0000 at n+1. m_ctrl 000, 010, 001, 100, 000, 000 at n+2. wb_ctrl 10, 11, 00, 00, 10, 00 at n+3.
- Load-use: LW rt=5, then R with rs_id=5 -> hazard_stall=1 for exactly one cycle; next ex_ctrl=0000 (bubble); bubble_cnt=1. Repeat with rt=0 -> no hazard.
- Stall: assert stall for 3 cycles mid-sequence -> ex_ctrl, m_ctrl, wb_ctrl and bubble_cnt unchanged. Progression resumes on the first edge after stall drops.
- Simultaneous flush + hazard, then stall + flush -> first inserts one bubble, bubble_cnt +1. Second: all stages hold and bubble_cnt does not change.
- Illegal/saturation:
  - opcode 111111, valid_id=1 -> illegal_op=1 for one cycle; all bundles 0.
  - With CNT_W=2, five flushes -> bubble_cnt stops at 3.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared opcodes, control field indices and bubble value
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_NOP   = 6'b100000;

   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

   localparam int M_BRANCH   = 2;
   localparam int M_MEMREAD  = 1;
   localparam int M_MEMWRITE = 0;

   localparam int EX_REGDST   = 3;
   localparam int EX_ALUOP_HI = 2;
   localparam int EX_ALUOP_LO = 1;
   localparam int EX_ALUSRC   = 0;

   typedef struct packed {
      logic [1:0] wb;
      logic [2:0] m;
      logic [3:0] ex;
   } ctrl_t;

   // A bubble is a fully deasserted control word: nothing writes, nothing branches.
   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode to WB/M/EX control decode
module ctrl_decode
   import mips_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter int WB_W     = 2,
   parameter int M_W      = 3,
   parameter int EX_W     = 4
) (
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                valid,
   output logic [WB_W-1:0]     wb,
   output logic [M_W-1:0]      m,
   output logic [EX_W-1:0]     ex,
   output logic                illegal
);

   always_comb begin
      wb      = '0;
      m       = '0;
      ex      = '0;
      illegal = 1'b0;
      if (valid) begin
         case (opcode)
            OPCODE_W'(OP_RTYPE): begin
               wb[WB_REGWRITE] = 1'b1;
               ex[EX_REGDST]   = 1'b1;
               ex[EX_ALUOP_HI] = 1'b1;
            end
            OPCODE_W'(OP_LW): begin
               wb[WB_REGWRITE] = 1'b1;
               wb[WB_MEMTOREG] = 1'b1;
               m[M_MEMREAD]    = 1'b1;
               ex[EX_ALUSRC]   = 1'b1;
            end
            OPCODE_W'(OP_SW): begin
               m[M_MEMWRITE] = 1'b1;
               ex[EX_ALUSRC] = 1'b1;
            end
            OPCODE_W'(OP_BEQ): begin
               m[M_BRANCH]     = 1'b1;
               ex[EX_ALUOP_LO] = 1'b1;
            end
            OPCODE_W'(OP_ADDI): begin
               wb[WB_REGWRITE] = 1'b1;
               ex[EX_ALUSRC]   = 1'b1;
            end
            OPCODE_W'(OP_NOP): ;
            default: illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/control_pipeline.sv
// rtl/control_pipeline.sv - decoded control carried through ID/EX, EX/MEM, MEM/WB
module control_pipeline
   import mips_ctrl_pkg::*;
#(
   parameter int OPCODE_W  = 6,
   parameter int REG_W     = 5,
   parameter int WB_W      = 2,
   parameter int M_W       = 3,
   parameter int EX_W      = 4,
   parameter int CNT_W     = 16,
   parameter int HAZARD_EN = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode_id,
   input  logic                valid_id,
   input  logic [REG_W-1:0]    rs_id,
   input  logic [REG_W-1:0]    rt_id,
   input  logic                stall,
   input  logic                flush,
   output logic [EX_W-1:0]     ex_ctrl,
   output logic [M_W-1:0]      m_ctrl,
   output logic [WB_W-1:0]     wb_ctrl,
   output logic                hazard_stall,
   output logic                illegal_op,
   output logic [CNT_W-1:0]    bubble_cnt
);

   logic [WB_W-1:0]  dec_wb;
   logic [M_W-1:0]   dec_m;
   logic [EX_W-1:0]  dec_ex;
   logic             dec_illegal;

   logic [WB_W-1:0]  s1_wb;
   logic [M_W-1:0]   s1_m;
   logic [EX_W-1:0]  s1_ex;
   logic [REG_W-1:0] s1_rt;
   logic             s1_illegal;
   logic [WB_W-1:0]  s2_wb;
   logic [M_W-1:0]   s2_m;
   logic [WB_W-1:0]  s3_wb;
   logic             insert_bubble;

   ctrl_decode #(
      .OPCODE_W (OPCODE_W),
      .WB_W     (WB_W),
      .M_W      (M_W),
      .EX_W     (EX_W)
   ) u_decode (
      .opcode  (opcode_id),
      .valid   (valid_id),
      .wb      (dec_wb),
      .m       (dec_m),
      .ex      (dec_ex),
      .illegal (dec_illegal)
   );

   // Load in ID/EX whose destination is read by the instruction now in ID.
   assign hazard_stall = (HAZARD_EN != 0) && valid_id && s1_m[M_MEMREAD] &&
                         (s1_rt != '0) && ((s1_rt == rs_id) || (s1_rt == rt_id));

   assign insert_bubble = flush || hazard_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_wb      <= '0;
         s1_m       <= '0;
         s1_ex      <= '0;
         s1_rt      <= '0;
         s1_illegal <= 1'b0;
         s2_wb      <= '0;
         s2_m       <= '0;
         s3_wb      <= '0;
         bubble_cnt <= '0;
      end else if (!stall) begin
         s2_wb <= s1_wb;
         s2_m  <= s1_m;
         s3_wb <= s2_wb;
         if (insert_bubble) begin
            s1_wb      <= WB_W'(CTRL_BUBBLE.wb);
            s1_m       <= M_W'(CTRL_BUBBLE.m);
            s1_ex      <= EX_W'(CTRL_BUBBLE.ex);
            s1_rt      <= '0;
            s1_illegal <= 1'b0;
            if (bubble_cnt != '1)
               bubble_cnt <= bubble_cnt + 1'b1;
         end else begin
            s1_wb      <= dec_wb;
            s1_m       <= dec_m;
            s1_ex      <= dec_ex;
            s1_rt      <= rt_id;
            s1_illegal <= dec_illegal;
         end
      end
   end

   assign ex_ctrl    = s1_ex;
   assign m_ctrl     = s2_m;
   assign wb_ctrl    = s3_wb;
   assign illegal_op = s1_illegal;

endmodule
